// File: rtl/vis_prefetch_if.sv
// Read-only bulk-fetch bus between vis_prefetch (master) and the correlator memory.
`ifndef ACCUM_BITS
`define ACCUM_BITS 32
`endif

interface vis_prefetch_if #(
  parameter int WIDTH = `ACCUM_BITS
);
  logic             cyc;
  logic             stb;
  logic             we;
  logic             bst;
  logic [9:0]       adr;
  logic             ack;
  logic [WIDTH-1:0] dat;

  modport master (output cyc, stb, we, bst, adr, input ack, dat);
  modport slave  (input cyc, stb, we, bst, adr, output ack, dat);
endinterface

// File: rtl/vis_prefetch.sv
// Double-buffered visibility prefetcher: each correlator bank swap triggers a bulk read of
// NBLK x NWRD words into the idle bank, which becomes readable once the whole frame lands.
`ifndef ACCUM_BITS
`define ACCUM_BITS 32
`endif

// state | meaning
// IDLE  | waiting for switch_i
// REQ   | bus transfer in flight, exactly one word outstanding
// DONE  | frame captured, swap banks
// ABORT | ack timeout, partial frame discarded
module vis_prefetch #(
  parameter int WIDTH   = `ACCUM_BITS,
  parameter int NBLK    = 6,
  parameter int NWRD    = 96,
  parameter int TIMEOUT = 255,
  localparam int DEPTH  = NBLK * NWRD,
  localparam int RAW    = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  input  logic                 switch_i,
  vis_prefetch_if.master       bus,
  input  logic [RAW-1:0]       rd_adr_i,
  output logic [WIDTH-1:0]     rd_dat_o,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic [7:0]           frame_o,
  output logic                 overflow_o,
  output logic                 error_o,
  input  logic                 clr_i
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ABORT} state_t;

  localparam int             TMW      = $clog2(TIMEOUT + 1);
  localparam logic [6:0]     WRD_LAST = 7'(NWRD - 1);
  localparam logic [2:0]     BLK_LAST = 3'(NBLK - 1);
  localparam logic [TMW-1:0] TMO_LAST = TMW'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [2:0]       blk_q, blk_d;
  logic [6:0]       wrd_q, wrd_d;
  logic [TMW-1:0]   tmo_q, tmo_d;
  logic             bank_q;
  logic             wr_en;
  logic             abort_set;
  logic [RAW-1:0]   wr_idx;
  logic [WIDTH-1:0] ram [2][DEPTH];

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      blk_q   <= '0;
      wrd_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      wrd_q   <= wrd_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    blk_d     = blk_q;
    wrd_d     = wrd_q;
    tmo_d     = tmo_q;
    wr_en     = 1'b0;
    abort_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (switch_i) begin
          state_d = REQ;
          blk_d   = '0;
          wrd_d   = '0;
          tmo_d   = '0;
        end
      end
      REQ: begin
        if (bus.ack) begin
          wr_en = 1'b1;
          tmo_d = '0;
          if (wrd_q == WRD_LAST) begin
            wrd_d = '0;
            blk_d = blk_q + 3'd1;
            if (blk_q == BLK_LAST) state_d = DONE;
          end else begin
            wrd_d = wrd_q + 7'd1;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d   = ABORT;
          abort_set = 1'b1;
        end else begin
          tmo_d = tmo_q + TMW'(1);
        end
      end
      DONE:    state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus strobes are decoded from the state flop so they fall as soon as rst_n drops.
  assign bus.cyc = (state_q == REQ);
  assign bus.stb = (state_q == REQ);
  assign bus.bst = (state_q == REQ);
  assign bus.we  = 1'b0;
  assign bus.adr = {blk_q, wrd_q};
  assign busy_o  = (state_q != IDLE);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      bank_q     <= 1'b0;
      frame_o    <= '0;
      ready_o    <= 1'b0;
      overflow_o <= 1'b0;
      error_o    <= 1'b0;
    end else begin
      if (state_q == DONE) begin
        bank_q  <= ~bank_q;
        frame_o <= frame_o + 8'd1;
        ready_o <= 1'b1;
      end
      if (switch_i && state_q != IDLE) overflow_o <= 1'b1;
      else if (clr_i)                  overflow_o <= 1'b0;
      if (abort_set)  error_o <= 1'b1;
      else if (clr_i) error_o <= 1'b0;
    end
  end

  // Fetch fills the inactive bank; the read port only ever sees the active one.
  assign wr_idx = RAW'(blk_q) * RAW'(NWRD) + RAW'(wrd_q);

  always_ff @(posedge clk_i) begin
    if (wr_en) ram[~bank_q][wr_idx] <= bus.dat;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) rd_dat_o <= '0;
    else        rd_dat_o <= ram[bank_q][rd_adr_i];
  end

endmodule

// File: tb/tb_vis_prefetch.sv
// Bench for vis_prefetch: randomized-latency bus responder plus a frame-level reference
// model of the readable bank contents, address order, timing and status flags.
module tb_vis_prefetch;
  localparam int W       = 32;
  localparam int NBLK    = 6;
  localparam int NWRD    = 96;
  localparam int TIMEOUT = 255;
  localparam int DEPTH   = NBLK * NWRD;
  localparam int RAW     = $clog2(DEPTH);

  logic           clk_i = 1'b0;
  logic           rst_n;
  logic           switch_i;
  logic           clr_i;
  logic [RAW-1:0] rd_adr_i;
  logic [W-1:0]   rd_dat_o;
  logic           ready_o;
  logic           busy_o;
  logic [7:0]     frame_o;
  logic           overflow_o;
  logic           error_o;

  vis_prefetch_if #(.WIDTH(W)) bus ();

  vis_prefetch #(.WIDTH(W), .NBLK(NBLK), .NWRD(NWRD), .TIMEOUT(TIMEOUT)) dut (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .switch_i   (switch_i),
    .bus        (bus),
    .rd_adr_i   (rd_adr_i),
    .rd_dat_o   (rd_dat_o),
    .ready_o    (ready_o),
    .busy_o     (busy_o),
    .frame_o    (frame_o),
    .overflow_o (overflow_o),
    .error_o    (error_o),
    .clr_i      (clr_i)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;

  // responder configuration (written by the main sequence only)
  int fixed_lat  = 1;
  int stop_after = -1;
  int dat_off    = 0;

  // responder bookkeeping (written by the responder only)
  int         n_ack    = 0;
  int         lat_sum  = 0;
  int         starve   = 0;
  int         stab_err = 0;
  logic [9:0] cap_q [$];

  // reference model: contents of the readable bank
  logic [W-1:0] exp_act [DEPTH];
  int           exp_frame = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] word_adr(input int i);
    return 10'(((i / NWRD) << 7) | (i % NWRD));
  endfunction

  // Slave: per word, waits a (fixed or random) number of cycles then acks with adr+offset.
  initial begin : responder
    int         cnt;
    int         cur_lat;
    bit         have_lat;
    logic [9:0] hold_adr;
    cnt = 0; cur_lat = 0; have_lat = 1'b0; hold_adr = '0;
    forever begin
      @(negedge clk_i);
      bus.ack = 1'b0;
      if (!rst_n || !bus.stb) begin
        have_lat = 1'b0;
        cnt      = 0;
      end else begin
        if (!have_lat) begin
          cur_lat  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
          hold_adr = bus.adr;
          have_lat = 1'b1;
          cnt      = 0;
        end else if (bus.adr != hold_adr) begin
          stab_err++;
        end
        if (stop_after >= 0 && n_ack >= stop_after) begin
          starve++;
        end else if (cnt >= cur_lat) begin
          bus.ack  = 1'b1;
          bus.dat  = W'(bus.adr) + W'(dat_off);
          cap_q.push_back(bus.adr);
          n_ack++;
          lat_sum += cur_lat + 1;
          have_lat = 1'b0;
        end else begin
          cnt++;
        end
      end
    end
  end

  task automatic run_frame(input int ovf_at, input bit rd_during, output int busy_cyc);
    int           guard;
    int           a;
    bit           pend;
    logic [W-1:0] pexp;
    pend = 1'b0; pexp = '0; busy_cyc = 0; guard = 0;
    switch_i = 1'b1;
    @(negedge clk_i);
    switch_i = 1'b0;
    while (busy_o && guard < 20000) begin
      if (pend) chk("rd_during_fetch", 64'(rd_dat_o), 64'(pexp));
      pend = 1'b0;
      if (busy_cyc == ovf_at) begin
        switch_i = 1'b1;
        clr_i    = 1'b1;
      end else begin
        switch_i = 1'b0;
        clr_i    = 1'b0;
      end
      if (rd_during) begin
        a        = int'($urandom_range(0, DEPTH - 1));
        rd_adr_i = RAW'(a);
        pexp     = exp_act[a];
        pend     = 1'b1;
      end
      busy_cyc++;
      guard++;
      @(negedge clk_i);
    end
    switch_i = 1'b0;
    clr_i    = 1'b0;
    if (pend) chk("rd_during_fetch", 64'(rd_dat_o), 64'(pexp));
    chk("frame_terminated", 64'(busy_o), 64'(0));
  endtask

  task automatic check_seq(input int c0, input int n);
    int mism;
    mism = 0;
    chk("ack_count", 64'(cap_q.size() - c0), 64'(n));
    for (int i = 0; i < n && (c0 + i) < cap_q.size(); i++)
      if (cap_q[c0 + i] != word_adr(i)) mism++;
    chk("adr_sequence", 64'(mism), 64'(0));
  endtask

  task automatic commit(input int off);
    for (int i = 0; i < DEPTH; i++) exp_act[i] = W'(word_adr(i)) + W'(off);
    exp_frame = (exp_frame + 1) % 256;
  endtask

  task automatic rd_check(input int n);
    int a;
    for (int k = 0; k < n; k++) begin
      a        = int'($urandom_range(0, DEPTH - 1));
      rd_adr_i = RAW'(a);
      @(negedge clk_i);
      chk("rd_data", 64'(rd_dat_o), 64'(exp_act[a]));
    end
  endtask

  task automatic pulse_clr();
    clr_i = 1'b1;
    @(negedge clk_i);
    clr_i = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int bc;
    int c0;
    int s0;
    int l0;
    int st0;
    int off;
    rst_n = 1'b0; switch_i = 1'b0; clr_i = 1'b0; rd_adr_i = '0;
    for (int i = 0; i < DEPTH; i++) exp_act[i] = '0;
    #1;
    chk("rst_cyc",      64'(bus.cyc),    64'(0));
    chk("rst_stb",      64'(bus.stb),    64'(0));
    chk("rst_bst",      64'(bus.bst),    64'(0));
    chk("rst_we",       64'(bus.we),     64'(0));
    chk("rst_adr",      64'(bus.adr),    64'(0));
    chk("rst_busy",     64'(busy_o),     64'(0));
    chk("rst_ready",    64'(ready_o),    64'(0));
    chk("rst_overflow", 64'(overflow_o), 64'(0));
    chk("rst_error",    64'(error_o),    64'(0));
    chk("rst_frame",    64'(frame_o),    64'(0));
    chk("rst_rd_dat",   64'(rd_dat_o),   64'(0));
    repeat (3) @(negedge clk_i);
    rst_n = 1'b1;
    @(negedge clk_i);

    // frame 1: 1-cycle latency, data = address
    fixed_lat = 1; dat_off = 0;
    c0 = cap_q.size(); s0 = stab_err;
    run_frame(-1, 1'b0, bc);
    chk("f1_busy_cycles", 64'(bc), 64'(DEPTH * 2 + 1));
    check_seq(c0, DEPTH);
    commit(0);
    chk("f1_ready",    64'(ready_o),  64'(1));
    chk("f1_frame",    64'(frame_o),  64'(exp_frame));
    chk("f1_error",    64'(error_o),  64'(0));
    chk("f1_overflow", 64'(overflow_o), 64'(0));
    chk("f1_adr_hold", 64'(stab_err - s0), 64'(0));
    rd_adr_i = RAW'(97);
    @(negedge clk_i);
    chk("rd_97", 64'(rd_dat_o), 64'('h081));
    rd_check(12);

    // frame 2: 3 wait cycles per word, address must hold
    fixed_lat = 3; dat_off = 500;
    c0 = cap_q.size(); s0 = stab_err;
    run_frame(-1, 1'b0, bc);
    chk("f2_busy_cycles", 64'(bc), 64'(DEPTH * 4 + 1));
    check_seq(c0, DEPTH);
    chk("f2_adr_hold", 64'(stab_err - s0), 64'(0));
    commit(500);
    chk("f2_frame", 64'(frame_o), 64'(exp_frame));
    rd_check(12);

    // frame 3: random per-word latency, random data offset
    fixed_lat = -1; off = int'($urandom_range(1, 50000)); dat_off = off;
    c0 = cap_q.size(); s0 = stab_err; l0 = lat_sum;
    run_frame(-1, 1'b0, bc);
    chk("f3_busy_cycles", 64'(bc), 64'(lat_sum - l0 + 1));
    check_seq(c0, DEPTH);
    chk("f3_adr_hold", 64'(stab_err - s0), 64'(0));
    commit(off);
    chk("f3_frame", 64'(frame_o), 64'(exp_frame));
    rd_check(12);

    // frame 4: reads during fetch must see the old frame
    fixed_lat = 1; dat_off = 1000;
    c0 = cap_q.size();
    run_frame(-1, 1'b1, bc);
    check_seq(c0, DEPTH);
    commit(1000);
    chk("f4_frame", 64'(frame_o), 64'(exp_frame));
    rd_check(16);

    // frame 5: switch mid-fetch together with clr; set wins, fetch unaffected
    fixed_lat = -1; dat_off = 2000;
    c0 = cap_q.size();
    run_frame(300, 1'b0, bc);
    check_seq(c0, DEPTH);
    commit(2000);
    chk("f5_overflow", 64'(overflow_o), 64'(1));
    chk("f5_frame",    64'(frame_o),    64'(exp_frame));
    rd_check(8);
    pulse_clr();
    chk("f5_overflow_clr", 64'(overflow_o), 64'(0));

    // frame 6: responder goes silent after 10 words -> timeout abort
    fixed_lat = 1; dat_off = 3000;
    stop_after = n_ack + 10; st0 = starve; c0 = cap_q.size();
    run_frame(-1, 1'b0, bc);
    chk("f6_acks",        64'(cap_q.size() - c0), 64'(10));
    chk("f6_starve",      64'(starve - st0),      64'(TIMEOUT));
    chk("f6_busy_cycles", 64'(bc), 64'(10 * 2 + TIMEOUT + 1));
    chk("f6_error",       64'(error_o), 64'(1));
    chk("f6_frame",       64'(frame_o), 64'(exp_frame));
    chk("f6_ready",       64'(ready_o), 64'(1));
    stop_after = -1;
    rd_check(12);
    pulse_clr();
    chk("f6_error_clr", 64'(error_o), 64'(0));

    // reset mid-fetch
    fixed_lat = 1; dat_off = 4000;
    switch_i = 1'b1;
    @(negedge clk_i);
    switch_i = 1'b0;
    repeat (100) @(negedge clk_i);
    chk("mid_busy_before_rst", 64'(busy_o), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_cyc",  64'(bus.cyc), 64'(0));
    chk("rst_async_stb",  64'(bus.stb), 64'(0));
    chk("rst_async_busy", 64'(busy_o),  64'(0));
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n = 1'b1;
    chk("post_rst_frame", 64'(frame_o),  64'(0));
    chk("post_rst_ready", 64'(ready_o),  64'(0));
    chk("post_rst_error", 64'(error_o),  64'(0));
    chk("post_rst_ovf",   64'(overflow_o), 64'(0));
    chk("post_rst_rd",    64'(rd_dat_o), 64'(0));
    exp_frame = 0;
    @(negedge clk_i);
    chk("post_rst_idle", 64'(busy_o), 64'(0));

    // frame after reset restarts cleanly from word 0
    fixed_lat = -1; dat_off = 5000;
    c0 = cap_q.size();
    run_frame(-1, 1'b0, bc);
    check_seq(c0, DEPTH);
    commit(5000);
    chk("f7_frame", 64'(frame_o), 64'(exp_frame));
    chk("f7_ready", 64'(ready_o), 64'(1));
    rd_check(12);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
